// File: rtl/calc_disp_pkg.sv
// Shared constants, segment decode and converter state encoding
// for the calculator display driver.
package calc_disp_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calc_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: signed value to sign + 3 BCD digits.
// Output digits only change on completion, never mid-conversion.
module bin2bcd_seq
    import calc_disp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         sign,
    output logic [11:0]  bcd
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    conv_state_t   state, state_n;
    logic [CW-1:0] bit_cnt;
    logic [W:0]    ext, absval, mag;
    logic [11:0]   scratch, adj;
    logic          scratch_sign;

    // Widened by one bit so the most negative value negates cleanly
    always_comb begin
        ext    = {value[W-1], value};
        absval = ext[W] ? -ext : ext;
    end

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (bit_cnt == CNT_LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            bit_cnt      <= '0;
            mag          <= '0;
            scratch      <= '0;
            scratch_sign <= 1'b0;
            sign         <= 1'b0;
            bcd          <= '0;
        end else begin
            busy <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        scratch      <= '0;
                        scratch_sign <= value[W-1];
                        mag          <= absval;
                        bit_cnt      <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= 12'({adj, mag[W-1]});
                    mag     <= mag << 1;
                    bit_cnt <= bit_cnt + CW'(1);
                end
                DONE: begin
                    bcd  <= scratch;
                    sign <= scratch_sign;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/calc_display_driver.sv
// 4-digit multiplexed 7-segment driver showing either the two operand
// digits or the signed ALU result converted to BCD.
module calc_display_driver
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int RESULT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          digit_a,
    input  logic [3:0]          digit_b,
    input  logic [RESULT_W-1:0] result,
    input  logic                show_result,
    output logic [6:0]          seg,
    output logic [3:0]          an,
    output logic                dp,
    output logic                busy
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]       ref_cnt;
    logic                wrap;
    logic [1:0]          scan_idx, idx_n;
    logic [RESULT_W-1:0] last_val;
    logic                start;
    logic                conv_sign;
    logic [11:0]         conv_bcd;
    logic [3:0]          hun, ten, one;
    logic [3:0][6:0]     d_seg;
    logic [6:0]          seg_n;

    assign dp = 1'b1;

    // busy low means the converter sits in IDLE and can accept work
    assign start = !busy && (result != last_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_val <= '0;
        else if (start) last_val <= result;
    end

    bin2bcd_seq #(
        .W(RESULT_W)
    ) u_conv (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .value(result),
        .busy (busy),
        .sign (conv_sign),
        .bcd  (conv_bcd)
    );

    assign wrap  = (ref_cnt == DIV_LAST);
    assign idx_n = scan_idx + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ref_cnt <= '0;
        else     ref_cnt <= wrap ? '0 : ref_cnt + CW'(1);
    end

    always_comb begin
        hun = conv_bcd[11:8];
        ten = conv_bcd[7:4];
        one = conv_bcd[3:0];
        if (show_result) begin
            d_seg[3] = conv_sign ? SEG_MINUS : SEG_BLANK;
            d_seg[2] = (hun == 4'd0) ? SEG_BLANK : bcd_to_seg(hun);
            d_seg[1] = (hun == 4'd0 && ten == 4'd0) ? SEG_BLANK
                                                    : bcd_to_seg(ten);
            d_seg[0] = bcd_to_seg(one);
        end else begin
            d_seg[3] = bcd_to_seg(digit_a);
            d_seg[2] = SEG_BLANK;
            d_seg[1] = SEG_BLANK;
            d_seg[0] = bcd_to_seg(digit_b);
        end
        seg_n = d_seg[idx_n];
    end

    // seg and an load together so no digit ever shows its neighbour's data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx <= 2'd0;
            seg      <= SEG_BLANK;
            an       <= 4'hF;
        end else if (wrap) begin
            scan_idx <= idx_n;
            seg      <= seg_n;
            an       <= ~(4'b0001 << idx_n);
        end
    end

endmodule

// File: tb/tb_calc_display_driver.sv
// Self-checking bench for calc_display_driver with a frame scoreboard.
// Expected display images are queued with the stimulus and checked per scan slot.
module tb_calc_display_driver;

    localparam int DIV = 4;
    localparam int W   = 8;

    localparam logic [6:0] TSEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06
    };

    typedef logic [3:0][6:0] frame_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   digit_a, digit_b;
    logic [W-1:0] result;
    logic         show_result;
    logic [6:0]   seg;
    logic [3:0]   an;
    logic         dp, busy;

    int     passed = 0;
    int     total  = 0;
    frame_t sb[$];

    int       mcnt;
    logic [1:0] midx;

    calc_display_driver #(
        .REFRESH_DIV(DIV),
        .RESULT_W   (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_a    (digit_a),
        .digit_b    (digit_b),
        .result     (result),
        .show_result(show_result),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference scan position: digit index lit after each refresh wrap
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= 0;
            midx <= 2'd0;
        end else if (mcnt == DIV - 1) begin
            mcnt <= 0;
            midx <= midx + 2'd1;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    function automatic frame_t op_frame(input int a, input int b);
        frame_t f;
        f[3] = TSEG[a];
        f[2] = 7'h7F;
        f[1] = 7'h7F;
        f[0] = TSEG[b];
        return f;
    endfunction

    function automatic frame_t res_frame(input int v);
        frame_t f;
        int m, h, t, o;
        m = (v < 0) ? -v : v;
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        f[3] = (v < 0) ? 7'h3F : 7'h7F;
        f[2] = (h == 0) ? 7'h7F : TSEG[h];
        f[1] = (h == 0 && t == 0) ? 7'h7F : TSEG[t];
        f[0] = TSEG[o];
        return f;
    endfunction

    task automatic wait_slot(output bit ok);
        logic [3:0] prev;
        prev = an;
        ok   = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (an !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frames(input string name);
        frame_t f;
        bit     ok;
        logic [3:0] exp_an;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        f = sb.pop_front();
        for (int s = 0; s < 4; s++) begin
            wait_slot(ok);
            total++;
            exp_an = ~(4'b0001 << midx);
            if (!ok) begin
                $display("FAIL %s slot%0d: an stuck at %h", name, s, an);
            end else if ({an, seg} !== {exp_an, f[midx]}) begin
                $display("FAIL %s slot%0d: an=%h seg=%h, want an=%h seg=%h",
                         name, s, an, seg, exp_an, f[midx]);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic wait_conv(output int highs);
        highs = 0;
        for (int i = 0; i < 80; i++) begin
            if (busy === 1'b1) highs++;
            else if (highs > 0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        digit_a     = 4'd7;
        digit_b     = 4'd3;
        result      = '0;
        show_result = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg);
        else passed++;
        total++;
        if (an !== 4'hF) $display("FAIL reset_an: got %h want f", an);
        else passed++;
        total++;
        if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < DIV - 1; i++) begin
            @(negedge clk);
            total++;
            if ({seg, an, busy} !== {7'h7F, 4'hF, 1'b0})
                $display("FAIL prewrap%0d: seg=%h an=%h busy=%b want 7f f 0",
                         i, seg, an, busy);
            else passed++;
        end
    endtask

    task automatic test_operands;
        sb.push_back(op_frame(7, 3));
        sb.push_back(op_frame(7, 3));
        check_frames("operands");
        check_frames("operands2");
    endtask

    task automatic test_result(input logic [W-1:0] v, input string name);
        int highs;
        result      = v;
        show_result = 1'b1;
        sb.push_back(res_frame(int'($signed(v))));
        wait_conv(highs);
        total++;
        if (highs !== W + 1)
            $display("FAIL %s_busy: high %0d clks want %0d", name, highs, W + 1);
        else passed++;
        check_frames(name);
    endtask

    task automatic test_back_to_back;
        frame_t f_old, f_a, f_b;
        int highs, rises, bad, lows;
        logic prev_busy;
        logic [3:0] prev_an;
        f_old = res_frame(-128);
        f_a   = res_frame(18);
        f_b   = res_frame(-5);
        result = 8'd18;
        sb.push_back(f_b);
        highs = 0; rises = 0; bad = 0; lows = 0;
        prev_busy = busy;
        prev_an   = an;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 2) result = 8'hFB;
            if (busy) begin
                highs++;
                lows = 0;
                if (!prev_busy) rises++;
            end else if (highs > 0) begin
                lows++;
            end
            prev_busy = busy;
            if (an !== prev_an) begin
                if (seg !== f_old[midx] && seg !== f_a[midx] && seg !== f_b[midx])
                    bad++;
                prev_an = an;
            end
            if (lows >= 3) break;
        end
        total++;
        if (highs !== 2 * (W + 1))
            $display("FAIL b2b_busy_len: got %0d want %0d", highs, 2 * (W + 1));
        else passed++;
        total++;
        if (rises !== 2) $display("FAIL b2b_busy_rises: got %0d want 2", rises);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL b2b_partial: %0d bad slots want 0", bad);
        else passed++;
        check_frames("b2b_final");
    endtask

    task automatic test_steady;
        int highs;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) highs++;
        end
        total++;
        if (highs !== 0) $display("FAIL steady_busy: got %0d want 0", highs);
        else passed++;
        show_result = 1'b0;
        sb.push_back(op_frame(7, 3));
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) highs++;
        end
        total++;
        if (highs !== 0) $display("FAIL toggle_busy: got %0d want 0", highs);
        else passed++;
        check_frames("view_toggle");
    endtask

    task automatic test_error_digit;
        digit_a = 4'hC;
        digit_b = 4'd5;
        sb.push_back(op_frame(12, 5));
        check_frames("error_digit");
    endtask

    task automatic test_reset_mid;
        int highs;
        show_result = 1'b1;
        result      = 8'd37;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({seg, an, dp, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0})
            $display("FAIL midrst_outputs: seg=%h an=%h dp=%b busy=%b want 7f f 1 0",
                     seg, an, dp, busy);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, an} !== {1'b1, 4'hF})
            $display("FAIL midrst_restart: busy=%b an=%h want 1 f", busy, an);
        else passed++;
        sb.push_back(res_frame(37));
        wait_conv(highs);
        total++;
        if (highs !== W + 1)
            $display("FAIL midrst_busy: high %0d clks want %0d", highs, W + 1);
        else passed++;
        check_frames("midrst_result");
    endtask

    initial begin
        test_reset();
        test_operands();
        test_result(8'd81, "res81");
        test_result(8'hF7, "res_m9");
        test_result(8'h80, "res_m128");
        test_back_to_back();
        test_steady();
        test_error_digit();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
